// File: rtl/mat_switch_arbiter.sv
// Shared send/recv switch for the mat cores: pairs a sender with the receiver that names it,
// round-robin across senders, one buffered vector in flight, and a sticky stall detector.
module mat_switch_arbiter #(
    parameter int SWITCH_WIDTH     = 16,
    parameter int SWITCH_CORE_SIZE = 4,
    parameter int STALL_CYCLES     = 256,
    localparam int SWITCH_CORE_ADDR_SIZE = (SWITCH_CORE_SIZE > 1) ? $clog2(SWITCH_CORE_SIZE) : 1
) (
    input  logic                                                     clock,
    input  logic                                                     reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                              send_ready,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]   send_core_idx,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]      send_data,
    output logic [SWITCH_CORE_SIZE-1:0]                              send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                              recv_request,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]   recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                              recv_ready,
    output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]      recv_data,
    output logic                                                     busy,
    output logic                                                     stall
);
    localparam int N     = SWITCH_CORE_SIZE;
    localparam int A     = SWITCH_CORE_ADDR_SIZE;
    localparam int CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_CYCLES - 1);

    typedef enum logic {IDLE, DELIVER} state_t;

    state_t                        state, next_state;
    logic [A-1:0]                  rr_ptr, src, dst;
    logic [A-1:0]                  win_src, win_dst, cand;
    logic [N-1:0]                  match;
    logic                          found, pending;
    logic [SWITCH_WIDTH-1:0][31:0] buffer;
    logic [CNT_W-1:0]              stall_cnt;

    // Looping over every destination also rejects index values >= N for free.
    always_comb begin
        match = '0;
        for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) begin
                if (d != s && send_ready[s] && send_core_idx[s] == A'(d) &&
                    recv_request[d] && recv_core_idx[d] == A'(s)) begin
                    match[s] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        found   = 1'b0;
        win_src = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = A'((int'(rr_ptr) + k) % N);
            if (!found && match[cand]) begin
                found   = 1'b1;
                win_src = cand;
            end
        end
        win_dst = send_core_idx[win_src];
        pending = (|send_ready) || (|recv_request);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = DELIVER;
            DELIVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pulses come only from registered state, so input glitches never reach the cores.
    always_comb begin
        send_ok    = '0;
        recv_ready = '0;
        busy       = (state == DELIVER);
        if (state == DELIVER) begin
            send_ok[src]    = 1'b1;
            recv_ready[dst] = 1'b1;
        end
    end

    assign recv_data = {N{buffer}};

    always_ff @(posedge clock) begin
        if (reset) begin
            buffer    <= '0;
            src       <= '0;
            dst       <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            stall     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        buffer    <= send_data[win_src];
                        src       <= win_src;
                        dst       <= win_dst;
                        stall_cnt <= '0;
                    end else if (pending) begin
                        if (stall_cnt == CNT_MAX) begin
                            stall <= 1'b1;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                DELIVER: begin
                    rr_ptr    <= (src == A'(N - 1)) ? '0 : src + 1'b1;
                    stall_cnt <= '0;
                    stall     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_switch_arbiter.sv
// Directed bench for mat_switch_arbiter: a table of single transfers from idle, then
// hand-written sequences for round-robin order, stall timing, reset during delivery and full traffic.
module tb_mat_switch_arbiter;
    localparam int N     = 4;
    localparam int W     = 16;
    localparam int STALL = 8;

    logic                     clock;
    logic                     reset;
    logic [N-1:0]             send_ready;
    logic [N-1:0][1:0]        send_core_idx;
    logic [N-1:0][W-1:0][31:0] send_data;
    logic [N-1:0]             send_ok;
    logic [N-1:0]             recv_request;
    logic [N-1:0][1:0]        recv_core_idx;
    logic [N-1:0]             recv_ready;
    logic [N-1:0][W-1:0][31:0] recv_data;
    logic                     busy;
    logic                     stall;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [3:0] send_ready;
        logic [7:0] send_idx;
        logic [3:0] recv_req;
        logic [7:0] recv_idx;
        logic [3:0] exp_ok;
        logic [3:0] exp_rdy;
        int         exp_src;
    } vec_t;

    vec_t table_v[8];

    mat_switch_arbiter #(
        .SWITCH_WIDTH     (W),
        .SWITCH_CORE_SIZE (N),
        .STALL_CYCLES     (STALL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .send_ready    (send_ready),
        .send_core_idx (send_core_idx),
        .send_data     (send_data),
        .send_ok       (send_ok),
        .recv_request  (recv_request),
        .recv_core_idx (recv_core_idx),
        .recv_ready    (recv_ready),
        .recv_data     (recv_data),
        .busy          (busy),
        .stall         (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // IEEE-754 single bits for a positive integer below 2^24.
    function automatic logic [31:0] fbits(int k);
        int e = 0;
        logic [31:0] m;
        for (int i = 0; i < 24; i++) if (k[i]) e = i;
        m = 32'(k - (1 << e)) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic logic [W-1:0][31:0] make_vec(int base);
        logic [W-1:0][31:0] v;
        for (int j = 0; j < W; j++) v[j] = fbits(base + j);
        return v;
    endfunction

    function automatic vec_t make_rec(string name, logic [3:0] sr, logic [7:0] sidx,
                                      logic [3:0] rq, logic [7:0] ridx,
                                      logic [3:0] ok, logic [3:0] rdy, int src);
        vec_t v;
        v.name = name; v.send_ready = sr; v.send_idx = sidx; v.recv_req = rq;
        v.recv_idx = ridx; v.exp_ok = ok; v.exp_rdy = rdy; v.exp_src = src;
        return v;
    endfunction

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        send_ready    = '0;
        send_core_idx = '0;
        recv_request  = '0;
        recv_core_idx = '0;
    endtask

    task automatic set_pair(int s, int d);
        send_ready[s]    = 1'b1;
        send_core_idx[s] = 2'(d);
        recv_request[d]  = 1'b1;
        recv_core_idx[d] = 2'(s);
    endtask

    task automatic drop_pair(int s, int d);
        send_ready[s]   = 1'b0;
        recv_request[d] = 1'b0;
    endtask

    task automatic expect_pulse(string name, logic [3:0] ok, logic [3:0] rdy);
        check({name, "_send_ok"}, send_ok, ok);
        check({name, "_recv_ready"}, recv_ready, rdy);
    endtask

    task automatic apply_stimulus(vec_t v, int r);
        send_ready    = v.send_ready;
        send_core_idx = v.send_idx;
        recv_request  = v.recv_req;
        recv_core_idx = v.recv_idx;
        for (int s = 0; s < N; s++) send_data[s] = make_vec(1 + 100 * r + 20 * s);
    endtask

    task automatic check_output(vec_t v, int r);
        int d = 0;
        expect_pulse(v.name, v.exp_ok, v.exp_rdy);
        check({v.name, "_busy"}, busy, v.exp_src >= 0);
        if (v.exp_src >= 0) begin
            for (int i = 0; i < N; i++) if (v.exp_rdy[i]) d = i;
            check({v.name, "_data"}, recv_data[d], make_vec(1 + 100 * r + 20 * v.exp_src));
        end else begin
            check({v.name, "_stall"}, stall, 1'b0);
        end
    endtask

    initial begin
        int seq[N];
        int last_svc[N];
        int served[N];

        table_v[0] = make_rec("r0_1to2",      4'b0010, {2'd0,2'd0,2'd2,2'd0}, 4'b0100, {2'd0,2'd1,2'd0,2'd0}, 4'b0010, 4'b0100, 1);
        table_v[1] = make_rec("r1_3to0",      4'b1000, {2'd0,2'd0,2'd0,2'd0}, 4'b0001, {2'd0,2'd0,2'd0,2'd3}, 4'b1000, 4'b0001, 3);
        table_v[2] = make_rec("r2_self",      4'b0100, {2'd0,2'd2,2'd0,2'd0}, 4'b0100, {2'd0,2'd2,2'd0,2'd0}, 4'b0000, 4'b0000, -1);
        table_v[3] = make_rec("r3_wrongsrc",  4'b0001, {2'd0,2'd0,2'd0,2'd1}, 4'b0010, {2'd0,2'd0,2'd3,2'd0}, 4'b0000, 4'b0000, -1);
        table_v[4] = make_rec("r4_two_to_2",  4'b0011, {2'd0,2'd0,2'd2,2'd2}, 4'b0100, {2'd0,2'd1,2'd0,2'd0}, 4'b0010, 4'b0100, 1);
        table_v[5] = make_rec("r5_recv_only", 4'b0000, {2'd0,2'd0,2'd0,2'd0}, 4'b1000, {2'd0,2'd0,2'd0,2'd0}, 4'b0000, 4'b0000, -1);
        table_v[6] = make_rec("r6_rr2",       4'b0101, {2'd0,2'd3,2'd0,2'd1}, 4'b1010, {2'd2,2'd0,2'd0,2'd0}, 4'b0100, 4'b1000, 2);
        table_v[7] = make_rec("r7_rr3",       4'b0101, {2'd0,2'd3,2'd0,2'd1}, 4'b1010, {2'd2,2'd0,2'd0,2'd0}, 4'b0001, 4'b0010, 0);

        // Reset with a valid pair presented: nothing may start.
        reset = 1'b1;
        clear_inputs();
        send_data = '0;
        set_pair(1, 2);
        tick();
        tick();
        check("rst_send_ok", send_ok, 4'b0);
        check("rst_recv_ready", recv_ready, 4'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_stall", stall, 1'b0);
        clear_inputs();
        reset = 1'b0;
        tick();

        // Round robin from rr_ptr=0: core0 first, core3 two cycles later.
        for (int s = 0; s < N; s++) send_data[s] = make_vec(1000 + 20 * s);
        set_pair(0, 1);
        set_pair(3, 2);
        tick();
        expect_pulse("rr0_first", 4'b0001, 4'b0010);
        check("rr0_first_data", recv_data[1], make_vec(1000));
        drop_pair(0, 1);
        tick();
        expect_pulse("rr0_gap", 4'b0000, 4'b0000);
        tick();
        expect_pulse("rr0_second", 4'b1000, 4'b0100);
        check("rr0_second_data", recv_data[2], make_vec(1060));
        drop_pair(3, 2);
        tick();
        set_pair(0, 1);
        tick();
        expect_pulse("rr_setup", 4'b0001, 4'b0010);
        drop_pair(0, 1);
        tick();
        // Now rr_ptr=1: core3 is reached before core0.
        set_pair(0, 1);
        set_pair(3, 2);
        tick();
        expect_pulse("rr1_first", 4'b1000, 4'b0100);
        drop_pair(3, 2);
        tick();
        tick();
        expect_pulse("rr1_second", 4'b0001, 4'b0010);
        drop_pair(0, 1);
        tick();

        // Core1 sends 1.0..16.0 to core2.
        send_data[1] = make_vec(1);
        set_pair(1, 2);
        tick();
        expect_pulse("t1", 4'b0010, 4'b0100);
        check("t1_busy", busy, 1'b1);
        check("t1_lane0", recv_data[2][0], 32'h3F80_0000);
        check("t1_lane15", recv_data[2][15], 32'h4180_0000);
        check("t1_data", recv_data[2], make_vec(1));
        clear_inputs();
        tick();
        check("t1_idle", busy, 1'b0);

        for (int r = 0; r < 8; r++) begin
            apply_stimulus(table_v[r], r);
            tick();
            check_output(table_v[r], r);
            clear_inputs();
            tick();
            check({table_v[r].name, "_idle"}, busy, 1'b0);
        end

        // Receiver names the wrong source: stall after exactly STALL unmatched cycles.
        send_data[0] = make_vec(3000);
        set_pair(0, 1);
        recv_core_idx[1] = 2'd2;
        for (int i = 0; i < STALL - 1; i++) tick();
        check("t3_no_pulse", send_ok, 4'b0);
        check("t3_stall_early", stall, 1'b0);
        tick();
        check("t3_stall", stall, 1'b1);
        recv_core_idx[1] = 2'd0;
        tick();
        expect_pulse("t3_fixed", 4'b0001, 4'b0010);
        check("t3_fixed_data", recv_data[1], make_vec(3000));
        check("t3_stall_in_deliver", stall, 1'b1);
        clear_inputs();
        tick();
        check("t3_stall_cleared", stall, 1'b0);

        // Self-send never matches but counts toward stall; other pairs still flow.
        send_ready[2] = 1'b1;
        send_core_idx[2] = 2'd2;
        recv_request[2] = 1'b1;
        recv_core_idx[2] = 2'd2;
        for (int i = 0; i < STALL; i++) tick();
        check("t4_stall", stall, 1'b1);
        check("t4_no_pulse", send_ok, 4'b0);
        send_data[0] = make_vec(4000);
        set_pair(0, 1);
        tick();
        expect_pulse("t4_pair", 4'b0001, 4'b0010);
        check("t4_pair_data", recv_data[1], make_vec(4000));
        drop_pair(0, 1);
        tick();
        check("t4_stall_cleared", stall, 1'b0);
        for (int i = 0; i < STALL - 1; i++) tick();
        check("t4_restall_early", stall, 1'b0);
        tick();
        check("t4_restall", stall, 1'b1);
        clear_inputs();
        tick();
        check("t4_sticky", stall, 1'b1);

        // Reset during DELIVER drops the transfer and returns rr_ptr to 0.
        send_data[2] = make_vec(5000);
        set_pair(2, 0);
        tick();
        expect_pulse("t5_pre", 4'b0100, 4'b0001);
        drop_pair(2, 0);
        tick();
        send_data[1] = make_vec(5100);
        send_data[3] = make_vec(5200);
        set_pair(1, 3);
        tick();
        check("t5_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        check("t5_rst_send_ok", send_ok, 4'b0);
        check("t5_rst_recv_ready", recv_ready, 4'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_stall", stall, 1'b0);
        reset = 1'b0;
        set_pair(3, 0);
        tick();
        expect_pulse("t5_retry", 4'b0010, 4'b1000);
        check("t5_retry_data", recv_data[3], make_vec(5100));
        drop_pair(1, 3);
        tick();
        tick();
        expect_pulse("t5_next", 4'b1000, 4'b0001);
        check("t5_next_data", recv_data[0], make_vec(5200));
        clear_inputs();
        tick();

        // Ring traffic: sender i -> i+1, every core always ready; each re-offers new data.
        for (int s = 0; s < N; s++) begin
            seq[s] = 0;
            last_svc[s] = -1;
            served[s] = 0;
            send_core_idx[s] = 2'((s + 1) % N);
            recv_core_idx[s] = 2'((s + N - 1) % N);
            send_data[s] = make_vec(6000 + 1000 * s);
        end
        send_ready = 4'hF;
        recv_request = 4'hF;
        for (int cyc = 0; cyc < 200; cyc++) begin
            tick();
            for (int s = 0; s < N; s++) begin
                if (send_ok[s]) begin
                    check("t6_recv_ready", recv_ready[(s + 1) % N], 1'b1);
                    check("t6_data", recv_data[(s + 1) % N], make_vec(6000 + 1000 * s + 16 * seq[s]));
                    check("t6_gap", (cyc - last_svc[s]) <= 2 * N, 1'b1);
                    last_svc[s] = cyc;
                    served[s]++;
                    seq[s]++;
                    send_data[s] = make_vec(6000 + 1000 * s + 16 * seq[s]);
                end
            end
        end
        for (int s = 0; s < N; s++) begin
            check("t6_served", served[s] >= 24, 1'b1);
            check("t6_final_gap", (199 - last_svc[s]) <= 2 * N, 1'b1);
        end
        clear_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
